// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
package prod_acc_pkg;

    localparam int PROD_W    = 16;
    localparam int FRAME_MAX = 256;
    localparam int CNT_W     = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Frame length as programmed: a zero field encodes a full 256-product frame.
    function automatic logic [CNT_W-1:0] resolve_len(input logic [7:0] len);
        logic [CNT_W-1:0] r;
        if (len == 8'd0) begin
            r = CNT_W'(FRAME_MAX);
        end else begin
            r = {1'b0, len};
        end
        return r;
    endfunction

endpackage

// File: rtl/prod_accumulator_in_reg.sv
// Stage-1 valid/ready register in front of the accumulator. It holds one
// product; new products are refused only while the accumulator sits in HOLD
// with this register already full.
module prod_in_reg
    import prod_acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [PROD_W-1:0] in_prod_i,
    input  logic              consume_i,
    input  logic              hold_i,
    output logic              in_ready_o,
    output logic [PROD_W-1:0] p_reg_o,
    output logic              p_vld_o
);

    logic              p_vld_q;
    logic              p_vld_d;
    logic [PROD_W-1:0] p_reg_q;
    logic [PROD_W-1:0] p_reg_d;
    logic              accept_s;

    assign in_ready_o = !p_vld_q || !hold_i;
    assign accept_s   = in_valid_i && in_ready_o;
    assign p_reg_o    = p_reg_q;
    assign p_vld_o    = p_vld_q;

    // Next-state of the holding register: flush drops everything, an accept
    // refills (even when the old value is consumed in the same cycle).
    always_comb begin
        p_vld_d = p_vld_q;
        p_reg_d = p_reg_q;
        if (flush_i) begin
            p_vld_d = 1'b0;
        end else if (accept_s) begin
            p_vld_d = 1'b1;
            p_reg_d = in_prod_i;
        end else if (consume_i) begin
            p_vld_d = 1'b0;
        end else begin
            p_vld_d = p_vld_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld_q <= 1'b0;
            p_reg_q <= {PROD_W{1'b0}};
        end else begin
            p_vld_q <= p_vld_d;
            p_reg_q <= p_reg_d;
        end
    end

endmodule

// File: rtl/prod_accumulator.sv
// Frame accumulator for the 8x8 multiplier product stream. Sums frame_len
// consecutive products and presents the sum on a valid/ready output.
// Build option PROD_ACC_SAT_EN: clamp the sum to all-ones on overflow
// instead of wrapping.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [7:0]        frame_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    acc_state_t        state_q;
    acc_state_t        state_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  len_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [PROD_W-1:0] p_reg_s;
    logic              p_vld_s;
    logic              consume_s;
    logic [ACC_W:0]    sum_s;
    logic              carry_s;
    logic [CNT_W-1:0]  len_new_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    prod_in_reg u_in_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_prod_i  (in_prod),
        .consume_i  (consume_s),
        .hold_i     (state_q == HOLD),
        .in_ready_o (in_ready),
        .p_reg_o    (p_reg_s),
        .p_vld_o    (p_vld_s)
    );

    assign consume_s = p_vld_s && (state_q != HOLD);
    assign sum_s     = {1'b0, acc_q} + (ACC_W+1)'(p_reg_s);
    assign carry_s   = sum_s[ACC_W];
    assign len_new_s = resolve_len(frame_len);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    // Frame FSM and accumulator next-state; flush overrides everything.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p_vld_s) begin
                        acc_d   = ACC_W'(p_reg_s);
                        len_d   = len_new_s;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = (len_new_s == CNT_W'(1)) ? HOLD : ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (p_vld_s) begin
                        cnt_d = cnt_inc_s;
                        ovf_d = ovf_q || carry_s;
`ifdef PROD_ACC_SAT_EN
                        // Once clamped, the sum stays pinned for the frame.
                        if (ovf_q || carry_s) begin
                            acc_d = ACC_MAX;
                        end else begin
                            acc_d = sum_s[ACC_W-1:0];
                        end
`else
                        acc_d = sum_s[ACC_W-1:0];
`endif
                        if (cnt_inc_s == len_q) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, accumulator, frame length and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= {ACC_W{1'b0}};
            len_q   <= {CNT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed scoreboard bench for prod_accumulator (24-bit instance plus a
// 16-bit instance for the overflow case).
module tb_prod_accumulator;

    localparam int ACC_W  = 24;
    localparam int ACC2_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [7:0]        frame_len;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;

    logic [7:0]        frame_len2;
    logic              in_valid2;
    logic              in_ready2;
    logic [15:0]       in_prod2;
    logic              out_valid2;
    logic              out_ready2;
    logic [ACC2_W-1:0] out_acc2;
    logic              out_ovf2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int res_cnt = 0;
    int accepted = 0;
    int last_acc_cyc = 0;
    int rise_cyc = 0;
    int or_hold_cnt = 0;
    logic [15:0]      inc_val;
    logic [ACC_W-1:0] last_res;
    logic             last_ovf;

    logic [ACC_W:0] exp_q[$];
    int     m_cnt = 0;
    int     m_len = 0;
    longint m_sum = 0;
    logic   m_ovf = 1'b0;
    longint acc_max = (longint'(1) << ACC_W) - 1;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    prod_accumulator #(.ACC_W(ACC2_W)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .frame_len(frame_len2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_prod(in_prod2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_acc(out_acc2), .out_ovf(out_ovf2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: add one accepted product to the frame in progress.
    task automatic model_add(input logic [15:0] p);
        if (m_cnt == 0) begin
            m_len = (frame_len == 8'd0) ? 256 : int'(frame_len);
            m_sum = 0;
            m_ovf = 1'b0;
        end
        m_sum = m_sum + longint'(p);
        if (m_sum > acc_max) begin
            m_ovf = 1'b1;
`ifdef PROD_ACC_SAT_EN
            m_sum = acc_max;
`else
            m_sum = m_sum - (acc_max + 1);
`endif
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_q.push_back({m_ovf, m_sum[ACC_W-1:0]});
            m_cnt = 0;
        end
    endtask

    // One clock: observe handshake at negedge, update inputs after posedge.
    task automatic step();
        logic acc_s;
        @(negedge clk);
        acc_s = in_valid && in_ready && rst_n;
        if (flush) begin
            m_cnt = 0;
        end else if (acc_s) begin
            last_acc_cyc = cyc;
            model_add(in_prod);
        end
        @(posedge clk);
        #1;
        if (or_hold_cnt > 0) begin
            out_ready = 1'b0;
            or_hold_cnt--;
        end else begin
            out_ready = 1'b1;
        end
        if (acc_s && !flush) begin
            accepted++;
            in_prod = in_prod + inc_val;
        end
    endtask

    task automatic send_n(input int n, input logic [15:0] val, input logic [15:0] inc);
        int start;
        int guard;
        start = accepted;
        guard = 0;
        inc_val = inc;
        in_prod = val;
        in_valid = 1'b1;
        while ((accepted - start) < n && guard < 4 * n + 50) begin
            step();
            guard++;
        end
        in_valid = 1'b0;
        check("send_done", accepted - start, n);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 300) begin
            step();
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: scoreboard pops on handshake, stability while held.
    initial begin
        logic             prev_hold;
        logic             prev_valid;
        logic [ACC_W-1:0] prev_acc;
        logic [ACC_W:0]   e;
        prev_hold  = 1'b0;
        prev_valid = 1'b0;
        prev_acc   = '0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (prev_hold && out_valid) check("hold_stable", out_acc, prev_acc);
            if (out_valid && out_ready) begin
                res_cnt++;
                check("result_queued", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_acc", out_acc, e[ACC_W-1:0]);
                    check("out_ovf", out_ovf, e[ACC_W]);
                    last_res = out_acc;
                    last_ovf = out_ovf;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_acc   = out_acc;
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int base;
        int start;
        logic [15:0] exp2;
`ifdef PROD_ACC_SAT_EN
        exp2 = 16'hFFFF;
`else
        exp2 = 16'hFC02;
`endif
        rst_n = 1'b1; flush = 1'b0; frame_len = 8'd8; in_valid = 1'b0;
        in_prod = 16'h0000; out_ready = 1'b1; inc_val = 16'h0000;
        frame_len2 = 8'd2; in_valid2 = 1'b0; in_prod2 = 16'h0000; out_ready2 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst16_out_valid", out_valid2, 0);
        check("rst16_in_ready", in_ready2, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: eight back-to-back 0xFE01 products.
        frame_len = 8'd8;
        base = res_cnt;
        send_n(8, 16'hFE01, 16'h0000);
        drain();
        check("t1_count", res_cnt - base, 1);
        check("t1_acc", last_res, 24'h07F008);
        check("t1_ovf", last_ovf, 0);
        check("t1_latency", rise_cyc - last_acc_cyc, 2);

        // 2: 16-bit accumulator overflow.
        in_prod2 = 16'hFE01;
        in_valid2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t2_in_ready", in_ready2, 1);
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b0;
        g = 0;
        while (!out_valid2 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("t2_valid", out_valid2, 1);
        check("t2_acc", out_acc2, exp2);
        check("t2_ovf", out_ovf2, 1);
        @(posedge clk);
        #1;

        // 3: frame_len 0 means 256 products.
        frame_len = 8'd0;
        base = res_cnt;
        send_n(255, 16'h0001, 16'h0000);
        repeat (6) step();
        check("t3_no_early", res_cnt - base, 0);
        check("t3_valid_low", out_valid, 0);
        send_n(1, 16'h0001, 16'h0000);
        drain();
        check("t3_count", res_cnt - base, 1);
        check("t3_acc", last_res, 24'h000100);

        // 4: single-product frames with output stalled for 5 cycles.
        frame_len = 8'd1;
        base = res_cnt;
        start = accepted;
        or_hold_cnt = 4;
        out_ready = 1'b0;
        inc_val = 16'h0001;
        in_prod = 16'h0101;
        in_valid = 1'b1;
        repeat (5) step();
        check("t4_extra_accept", accepted - start, 2);
        check("t4_in_ready_low", in_ready, 0);
        check("t4_held_valid", out_valid, 1);
        send_n(4, in_prod, 16'h0001);
        drain();
        check("t4_count", res_cnt - base, 6);
        check("t4_last_acc", last_res, 24'h000106);

        // 5: flush after 3 of 4 products, input valid in the flush cycle.
        frame_len = 8'd4;
        base = res_cnt;
        send_n(3, 16'h0010, 16'h0000);
        flush = 1'b1;
        in_valid = 1'b1;
        in_prod = 16'h0010;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (6) step();
        check("t5_no_result", res_cnt - base, 0);
        check("t5_valid_low", out_valid, 0);
        send_n(4, 16'h0010, 16'h0000);
        drain();
        check("t5_count", res_cnt - base, 1);
        check("t5_acc", last_res, 24'h000040);

        // 6: reset mid-frame and in HOLD.
        send_n(2, 16'h0100, 16'h0000);
        rst_n = 1'b0;
        #1;
        check("t6a_in_ready", in_ready, 1);
        check("t6a_out_valid", out_valid, 0);
        check("t6a_out_acc", out_acc, 0);
        check("t6a_out_ovf", out_ovf, 0);
        exp_q.delete();
        m_cnt = 0;
        step();
        rst_n = 1'b1;
        or_hold_cnt = 1000;
        out_ready = 1'b0;
        send_n(4, 16'h0100, 16'h0000);
        repeat (3) step();
        check("t6b_in_hold", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6b_in_ready", in_ready, 1);
        check("t6b_out_valid", out_valid, 0);
        check("t6b_out_acc", out_acc, 0);
        check("t6b_out_ovf", out_ovf, 0);
        exp_q.delete();
        m_cnt = 0;
        or_hold_cnt = 0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        base = res_cnt;
        send_n(4, 16'h0100, 16'h0000);
        drain();
        check("t6_count", res_cnt - base, 1);
        check("t6_acc", last_res, 24'h000400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
